// File: rtl/rand_pkg.sv
// Shared types and helpers for the random-draw consumer of the LFSR stream.
// The mask helper gives the smallest all-ones window covering [0, limit).
package rand_pkg;

  localparam int RAND_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // limit==0 stands for 2^w, so the full w-bit window is returned.
  function automatic logic [31:0] range_mask(
    input logic [31:0] limit,
    input int          w
  );
    logic [31:0] m;
    if (limit == 32'd0) begin
      m = (32'd1 << w) - 32'd1;
    end else begin
      m = limit - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_range_draw.sv
// Unbiased integer draw in [0, Limit) by masked rejection sampling,
// with a bounded retry count and a fold fallback on the last try.
module rand_range_draw
  import rand_pkg::*;
#(
  parameter int W         = RAND_W,
  parameter int MAX_TRIES = 8
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [W-1:0]                     Rand,
  input  logic                             Req,
  input  logic [W-1:0]                     Limit,
  output logic                             Busy,
  output logic                             Valid,
  output logic [W-1:0]                     Value,
  output logic [$clog2(MAX_TRIES+1)-1:0]   Retries,
  output logic                             Fallback
);

  localparam int RW = $clog2(MAX_TRIES + 1);

  state_t        state_q;
  state_t        state_d;
  logic [W:0]    lim_q;
  logic [W-1:0]  mask_q;
  logic [RW-1:0] cnt_q;

  logic [W-1:0]  cand;
  logic [W-1:0]  fold;
  logic          hit;
  logic          last;
  logic          accept;
  logic          finish;
  logic          use_fold;
  logic          inc;

  // lim_q carries an extra bit so that Limit==0 compares as 2^W.
  always_comb begin
    cand = Rand & mask_q;
    hit  = {1'b0, cand} < lim_q;
    last = (cnt_q == RW'(MAX_TRIES - 1));
    fold = cand - lim_q[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    finish   = 1'b0;
    use_fold = 1'b0;
    inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          accept  = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (hit) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          finish   = 1'b1;
          use_fold = 1'b1;
          state_d  = IDLE;
        end else begin
          inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lim_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      Valid    <= 1'b0;
      Value    <= '0;
      Retries  <= '0;
      Fallback <= 1'b0;
    end else begin
      Valid <= finish;
      if (accept) begin
        lim_q  <= (Limit == '0) ? {1'b1, {W{1'b0}}}
                                : {1'b0, Limit};
        mask_q <= W'(range_mask(32'(Limit), W));
        cnt_q  <= '0;
      end
      if (inc) begin
        cnt_q <= cnt_q + RW'(1);
      end
      if (finish) begin
        Value    <= use_fold ? fold : cand;
        Retries  <= use_fold ? RW'(MAX_TRIES) : cnt_q;
        Fallback <= use_fold;
      end
    end
  end

  assign Busy = (state_q == DRAW);

endmodule
